pid_correction_snapshot_ctrl: RTL

Snapshot controller sitting between the NUM_CH per-motor PID correction outputs and the HPS lightweight Avalon-MM bridge. On a software request it captures one fresh correction from every enabled channel into shadow registers and commits them atomically to a readable bank, so the HPS never sees a mix of old and new control cycles. It also provides a sequence counter, timeout and overrun detection, and a completion interrupt.

---
 rtl/pid_corr_pkg.sv | 16 +
 rtl/pid_corr_ch_capture.sv | 27 ++
 rtl/pid_correction_snapshot_ctrl.sv | 110 +++++++++++
 3 files changed

// File: rtl/pid_corr_pkg.sv
// pid_corr_pkg: register offsets, STATUS/CONTROL bit positions, FSM states and SEQ width for the snapshot controller
package pid_corr_pkg;
  localparam logic [3:0] ADDR_STATUS = 4'd0;
  localparam logic [3:0] ADDR_CONTROL = 4'd1;
  localparam logic [3:0] ADDR_SEQ = 4'd2;
  localparam logic [3:0] ADDR_OVERRUN = 4'd3;
  localparam logic [3:0] ADDR_SNAP0 = 4'd4;
  localparam int STAT_DONE = 0;
  localparam int STAT_TIMEOUT = 1;
  localparam int STAT_BUSY = 31;
  localparam int CTRL_START = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_MASK_LSB = 8;
  localparam int SEQ_W = 16;
  typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_COMMIT} state_t;
endpackage

// File: rtl/pid_corr_ch_capture.sv
// pid_corr_ch_capture: per-channel first-strobe shadow capture (clear, en, valid, data in; shadow, got, overrun pulse out)
module pid_corr_ch_capture #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              en,
  input  logic              valid,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] shadow,
  output logic              got,
  output logic              overrun
);
  assign overrun = en && valid && got;
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow <= '0;
      got <= 1'b0;
    end else if (clear) begin
      got <= 1'b0;
    end else if (en && valid && !got) begin
      shadow <= data;
      got <= 1'b1;
    end
  end
endmodule

// File: rtl/pid_correction_snapshot_ctrl.sv
// pid_correction_snapshot_ctrl: atomic PID correction snapshot bank on Avalon-MM (corr_data/corr_valid in; address/write/writedata in, readdata/irq out)
module pid_correction_snapshot_ctrl
  import pid_corr_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 32,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH*DATA_W-1:0] corr_data,
  input  logic [NUM_CH-1:0]        corr_valid,
  input  logic [3:0]               address,
  input  logic                     write,
  input  logic [31:0]              writedata,
  output logic [31:0]              readdata,
  output logic                     irq
);
  localparam int CNT_W = TIMEOUT_CYC > 1 ? $clog2(TIMEOUT_CYC) : 1;
  state_t state;
  logic [NUM_CH-1:0] active, en_mask, got, ovr_hit, overrun;
  logic [NUM_CH-1:0][DATA_W-1:0] shadow, snap;
  logic [SEQ_W-1:0] seq;
  logic [CNT_W-1:0] cnt;
  logic done, timeout, irq_en;
  logic wr_status, wr_control, wr_ovr, start, armed, all_got, expire;
  logic [31:0] rd;
  logic unused;
  assign unused = ^writedata;
  assign wr_status = write && address == ADDR_STATUS;
  assign wr_control = write && address == ADDR_CONTROL;
  assign wr_ovr = write && address == ADDR_OVERRUN;
  assign start = wr_control && writedata[CTRL_START] && state == ST_IDLE;
  assign armed = state == ST_ARMED;
  // completion counts strobes arriving this very cycle, so it beats a simultaneous expiry
  assign all_got = &(got | (active & corr_valid) | ~active);
  assign expire = armed && !all_got && cnt == '0;
  assign irq = done && irq_en;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pid_corr_ch_capture #(.DATA_W(DATA_W)) u_cap (
      .clk(clk),
      .reset(reset),
      .clear(start),
      .en(armed && active[i]),
      .valid(corr_valid[i]),
      .data(corr_data[i*DATA_W +: DATA_W]),
      .shadow(shadow[i]),
      .got(got[i]),
      .overrun(ovr_hit[i])
    );
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      active <= '0;
      cnt <= '0;
      seq <= '0;
      snap <= '0;
      done <= 1'b0;
      timeout <= 1'b0;
      irq_en <= 1'b0;
      en_mask <= '1;
      overrun <= '0;
      readdata <= '0;
    end else begin
      readdata <= rd;
      if (wr_control) begin
        irq_en <= writedata[CTRL_IRQ_EN];
        en_mask <= writedata[CTRL_MASK_LSB +: NUM_CH];
      end
      done <= state == ST_COMMIT || (done && !(wr_status && writedata[STAT_DONE]));
      timeout <= expire || (timeout && !(wr_status && writedata[STAT_TIMEOUT]));
      overrun <= ovr_hit | (overrun & ~({NUM_CH{wr_ovr}} & writedata[NUM_CH-1:0]));
      case (state)
        ST_IDLE: if (start) begin
          state <= ST_ARMED;
          active <= writedata[CTRL_MASK_LSB +: NUM_CH];
          cnt <= CNT_W'(TIMEOUT_CYC - 1);
        end
        ST_ARMED: begin
          if (all_got) state <= ST_COMMIT;
          else if (cnt == '0) state <= ST_IDLE;
          else cnt <= cnt - 1'b1;
        end
        ST_COMMIT: begin
          state <= ST_IDLE;
          seq <= seq + 1'b1;
          for (int i = 0; i < NUM_CH; i++) if (active[i]) snap[i] <= shadow[i];
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
  always_comb begin
    rd = '0;
    if (address == ADDR_STATUS) begin
      rd[STAT_DONE] = done;
      rd[STAT_TIMEOUT] = timeout;
      rd[STAT_BUSY] = state != ST_IDLE;
    end else if (address == ADDR_CONTROL) begin
      rd[CTRL_IRQ_EN] = irq_en;
      rd[CTRL_MASK_LSB +: NUM_CH] = en_mask;
    end else if (address == ADDR_SEQ) begin
      rd[SEQ_W-1:0] = seq;
    end else if (address == ADDR_OVERRUN) begin
      rd[NUM_CH-1:0] = overrun;
    end
    for (int i = 0; i < NUM_CH; i++) if (address == ADDR_SNAP0 + 4'(i)) rd[DATA_W-1:0] = snap[i];
  end
endmodule
